// File: rtl/sr_trace_uart_tx.sv
// sr_trace_uart_tx: captures pc/instr/a0 on each retire strobe and sends them
// as one ASCII line "pppppppp iiiiiiii aaaaaaaa\r\n" over a UART 8N1 link.
module sr_trace_uart_tx #(
  parameter int unsigned CLK_DIV = 868,
  parameter int unsigned DROP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trace_valid,
  input  logic [31:0]       trace_pc,
  input  logic [31:0]       trace_instr,
  input  logic [31:0]       trace_a0,
  output logic              tx,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [15:0] BaudReload = 16'(CLK_DIV - 1);
  localparam logic [4:0]  LastChar   = 5'd27;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} stateT;

  stateT       state;
  logic [95:0] capture;    // {pc, instr, a0}
  logic [7:0]  shiftReg;
  logic [15:0] baudCnt;
  logic [2:0]  bitIdx;
  logic [4:0]  charIdx;

  logic [7:0]  charByte;
  logic [6:0]  charOff;
  logic [6:0]  shAmt;
  logic [3:0]  nibble;
  logic        isHex;

  // Character of the line selected by charIdx, built from the capture register.
  always_comb begin
    charByte = 8'h20;
    isHex    = 1'b0;
    shAmt    = 7'd0;
    charOff  = {charIdx, 2'b00};
    // Each field skips one separator char, so the nibble shift per field
    // differs by 4 on top of the 32-bit field stride.
    if (charIdx < 5'd8) begin
      isHex = 1'b1;
      shAmt = 7'd92 - charOff;
    end else if (charIdx >= 5'd9 && charIdx <= 5'd16) begin
      isHex = 1'b1;
      shAmt = 7'd96 - charOff;
    end else if (charIdx >= 5'd18 && charIdx <= 5'd25) begin
      isHex = 1'b1;
      shAmt = 7'd100 - charOff;
    end else if (charIdx == 5'd26) begin
      charByte = 8'h0d;
    end else if (charIdx == 5'd27) begin
      charByte = 8'h0a;
    end
    nibble = 4'(capture >> shAmt);
    if (isHex) begin
      if (nibble < 4'd10) charByte = 8'h30 + {4'h0, nibble};
      else                charByte = 8'h57 + {4'h0, nibble};
    end
  end

  // Line transmitter FSM: accept, then start/data/stop per character, 28 chars.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      tx       <= 1'b1;
      busy     <= 1'b0;
      capture  <= '0;
      shiftReg <= '0;
      baudCnt  <= '0;
      bitIdx   <= '0;
      charIdx  <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          tx <= 1'b1;
          if (trace_valid) begin
            capture <= {trace_pc, trace_instr, trace_a0};
            busy    <= 1'b1;
            tx      <= 1'b0;
            charIdx <= '0;
            baudCnt <= BaudReload;
            state   <= StStart;
          end
        end
        StStart: begin
          if (baudCnt == 16'd0) begin
            // Capture is stable here, so the character is loaded at frame start.
            shiftReg <= charByte;
            tx       <= charByte[0];
            bitIdx   <= '0;
            baudCnt  <= BaudReload;
            state    <= StData;
          end else begin
            baudCnt <= baudCnt - 16'd1;
          end
        end
        StData: begin
          if (baudCnt == 16'd0) begin
            baudCnt <= BaudReload;
            if (bitIdx == 3'd7) begin
              tx    <= 1'b1;
              state <= StStop;
            end else begin
              bitIdx   <= bitIdx + 3'd1;
              shiftReg <= {1'b0, shiftReg[7:1]};
              tx       <= shiftReg[1];
            end
          end else begin
            baudCnt <= baudCnt - 16'd1;
          end
        end
        StStop: begin
          if (baudCnt == 16'd0) begin
            baudCnt <= BaudReload;
            if (charIdx == LastChar) begin
              busy  <= 1'b0;
              state <= StIdle;
            end else begin
              charIdx <= charIdx + 5'd1;
              tx      <= 1'b0;
              state   <= StStart;
            end
          end else begin
            baudCnt <= baudCnt - 16'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Saturating count of strobes that arrive while a line is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (trace_valid && busy && (drop_cnt != {DROP_W{1'b1}})) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sr_trace_uart_tx.sv
// Directed bench for sr_trace_uart_tx with a cycle-aligned UART line receiver.
module tb_sr_trace_uart_tx;

  localparam int unsigned ClkDiv = 4;
  localparam int unsigned DropW  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             trace_valid = 1'b0;
  logic [31:0]      trace_pc = '0;
  logic [31:0]      trace_instr = '0;
  logic [31:0]      trace_a0 = '0;
  logic             tx;
  logic             busy;
  logic [DropW-1:0] drop_cnt;

  int errCnt = 0;
  int chkCnt = 0;
  int frameErr = 0;
  int busyCycles = 0;
  logic [7:0] rxBuf [28];

  sr_trace_uart_tx #(
    .CLK_DIV(ClkDiv),
    .DROP_W (DropW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trace_valid(trace_valid),
    .trace_pc   (trace_pc),
    .trace_instr(trace_instr),
    .trace_a0   (trace_a0),
    .tx         (tx),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic strobe(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] a0);
    @(negedge clk);
    trace_valid = 1'b1;
    trace_pc    = pc;
    trace_instr = instr;
    trace_a0    = a0;
    @(negedge clk);
    trace_valid = 1'b0;
  endtask

  // Receives 28 characters, sampling one negedge into each start bit and then every ClkDiv.
  task automatic recvLine();
    int n;
    frameErr = 0;
    for (int c = 0; c < 28; c++) begin
      n = 0;
      while (tx !== 1'b0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (tx !== 1'b0) begin
        chk("rx_start_timeout", 32'(tx), 32'd0);
        return;
      end
      @(negedge clk);
      if (tx !== 1'b0) frameErr++;
      for (int b = 0; b < 8; b++) begin
        repeat (ClkDiv) @(negedge clk);
        rxBuf[c][b] = tx;
      end
      repeat (ClkDiv) @(negedge clk);
      if (tx !== 1'b1) frameErr++;
    end
  endtask

  task automatic checkLine(input string tag, input string exp);
    for (int i = 0; i < 26; i++) begin
      chk($sformatf("%s_char%0d", tag, i), 32'(rxBuf[i]), 32'(exp.getc(i)));
    end
    chk({tag, "_cr"}, 32'(rxBuf[26]), 32'h0d);
    chk({tag, "_lf"}, 32'(rxBuf[27]), 32'h0a);
    chk({tag, "_framing"}, 32'(frameErr), 32'd0);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int bad;
    // Reset and idle line
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    chk("idle_tx_steady", 32'(bad), 32'd0);

    // Single trace with busy-length measurement
    strobe(32'h0000_0004, 32'h00a0_0513, 32'h0000_000a);
    fork
      recvLine();
      begin
        busyCycles = 0;
        while (busy === 1'b1 && busyCycles < 2000) begin
          busyCycles++;
          @(negedge clk);
        end
      end
    join
    checkLine("single", "00000004 00a00513 0000000a");
    chk("busy_cycles", 32'(busyCycles), 32'd1120);

    // Full hex digit range
    strobe(32'hfedc_ba98, 32'h0123_4567, 32'hffff_ffff);
    recvLine();
    checkLine("hex", "fedcba98 01234567 ffffffff");
    waitIdle();

    // Three strobes back to back: only the first is sent
    @(negedge clk);
    trace_valid = 1'b1;
    trace_pc = 32'h0000_0100; trace_instr = 32'h00b5_0533; trace_a0 = 32'h0000_0014;
    @(negedge clk);
    trace_pc = 32'hdead_beef; trace_instr = 32'h1111_1111; trace_a0 = 32'h2222_2222;
    @(negedge clk);
    trace_pc = 32'h3333_3333; trace_instr = 32'h4444_4444; trace_a0 = 32'h5555_5555;
    @(negedge clk);
    trace_valid = 1'b0;
    recvLine();
    checkLine("drop_line", "00000100 00b50533 00000014");
    chk("drop_cnt_two", 32'(drop_cnt), 32'd2);
    // Strobe on the final stop cycle is dropped, one cycle later is accepted
    repeat (2) @(negedge clk);
    chk("last_stop_busy", 32'(busy), 32'd1);
    trace_valid = 1'b1;
    trace_pc = 32'h6666_6666; trace_instr = 32'h7777_7777; trace_a0 = 32'h8888_8888;
    @(negedge clk);
    chk("boundary_drop", 32'(drop_cnt), 32'd3);
    chk("boundary_idle", 32'(busy), 32'd0);
    trace_pc = 32'h0000_010c; trace_instr = 32'hfff5_0513; trace_a0 = 32'h0000_0013;
    @(negedge clk);
    trace_valid = 1'b0;
    chk("boundary_accept", 32'(busy), 32'd1);
    recvLine();
    checkLine("boundary_line", "0000010c fff50513 00000013");
    waitIdle();

    // Saturation of the 2-bit drop counter
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("sat_cleared", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    trace_valid = 1'b1;
    trace_pc = 32'h1111_1111; trace_instr = 32'h2222_2222; trace_a0 = 32'h3333_3333;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 2) chk("sat_mid", 32'(drop_cnt), 32'd2);
    end
    @(negedge clk);
    trace_valid = 1'b0;
    chk("sat_reach", 32'(drop_cnt), 32'd3);
    repeat (10) @(negedge clk);
    chk("sat_hold", 32'(drop_cnt), 32'd3);

    // Reset during DATA bit 3 of char 5 ('1' = 0x31, bit 3 is 0)
    repeat (202) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_bit3", 32'(tx), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_tx", 32'(tx), 32'd1);
    strobe(32'h0000_0200, 32'h00a5_8593, 32'hcafe_0001);
    recvLine();
    checkLine("post_rst_line", "00000200 00a58593 cafe0001");
    waitIdle();

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errCnt);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sr_trace_uart_tx.md
# sr_trace_uart_tx

Hardware trace transmitter for the schoolRISCV CPU. It is the transmitting end of the per-instruction debug trace that the simulation bench prints. On each retire strobe it captures `pc`, `instr` and register `a0` (x10). It then serialises them as one ASCII text line over a UART 8N1 link, so a board can stream the same trace to a host terminal. It sits beside `sm_cpu` inside `sm_top`, clocked by the CPU clock, and has no effect on CPU execution.

## Interface
Parameters:
- `CLK_DIV`, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range is 2 to 65535.
- `DROP_W`, default 8: width of the saturating dropped-trace counter.

Ports:
- `clk`  in  1: clock. Everything is sampled on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `trace_valid`  in  1: single-cycle strobe; one instruction has retired.
- `trace_pc`  in  32: PC of the retired instruction.
- `trace_instr`  in  32: instruction word.
- `trace_a0`  in  32: value of x10 after the instruction.
- `tx`  out  1: UART serial output. Idle level is 1.
- `busy`  out  1: a line is being transmitted; new traces are dropped while high.
- `drop_cnt`  out  DROP_W: count of traces lost while busy. Saturates at all-ones.

## Operation
- Reset drives `tx`=1, `busy`=0, `drop_cnt`=0, FSM to IDLE, and clears the baud counter, bit index and char index. Reset takes effect immediately, including mid-frame; no partial character completes.
- Accept: `trace_valid`=1 with `busy`=0 latches pc, instr and a0 into a 96-bit capture register at that edge. `busy` goes to 1 at the same edge.
- Drop: `trace_valid`=1 with `busy`=1 increments `drop_cnt` unless it is already all-ones. The capture register is unchanged.
- Line format is 28 characters, index 0 to 27:
  - indices 0-7: pc as 8 hex digits, MSB nibble first
  - index 8: space (0x20)
  - indices 9-16: instr as 8 hex digits
  - index 17: space
  - indices 18-25: a0 as 8 hex digits
  - index 26: CR (0x0D)
  - index 27: LF (0x0A)
- Hex digit encoding is lowercase: nibble 0-9 maps to 0x30-0x39, nibble 10-15 maps to 0x61-0x66.
- The character byte is a combinational mux of the capture register and char index. It is registered into the shift register at the start of each frame.
- FSM states and transitions:
  - IDLE: `tx`=1. An accept moves to START with char index 0.
  - START: `tx`=0 for CLK_DIV cycles, then DATA with bit index 0.
  - DATA: `tx`=shift[0], LSB first, CLK_DIV cycles per bit. After bit 7, go to STOP.
  - STOP: `tx`=1 for CLK_DIV cycles. Then:
    - if char index < 27: increment it and return to START;
    - if char index = 27: go to IDLE and clear `busy`.
- The baud counter reloads to CLK_DIV-1 on every state or bit change and counts down to 0. Its width is 16 bits.
- There is no gap between consecutive characters of a line: each stop bit is followed directly by the next start bit.

## Timing
- Start bit: for a `trace_valid` accepted at edge E, `tx` goes low in the cycle after E.
- Each frame lasts 10*CLK_DIV cycles. A full line lasts 280*CLK_DIV cycles.
- `busy` is high from edge E through the final stop-bit cycle. It drops at edge E+280*CLK_DIV.
- Boundary case: `trace_valid` in the same cycle that `busy` is still 1 (the last stop cycle) is a drop. A strobe in the next cycle is accepted.
- `drop_cnt` updates one edge after the dropped strobe.
- All outputs (`tx`, `busy`, `drop_cnt`) are registered. None has a combinational path from any input.

## Test plan
- Reset: assert `rst` for 3 cycles. Required: `tx`=1, `busy`=0, `drop_cnt`=0, with `tx` steady for 1000 cycles afterwards.
- Single trace, CLK_DIV=4: pc=0x00000004, instr=0x00a00513, a0=0x0000000a. A UART monitor must decode exactly "00000004 00a00513 0000000a\r\n". `busy` must be high for exactly 1120 cycles.
- Hex range: pc=0xfedcba98, instr=0x01234567, a0=0xffffffff. Required line: "fedcba98 01234567 ffffffff\r\n", with digits a-f sent as 0x61-0x66.
- Drop handling: three strobes in consecutive cycles. Required: only the first line is transmitted and `drop_cnt`=2. A strobe exactly at the final stop cycle increments `drop_cnt`; a strobe one cycle later starts a new line.
- Saturation, DROP_W=2: five strobes while busy. Required: `drop_cnt` reaches 3 and holds there.
- Reset mid-frame: assert `rst` during the DATA bit 3 of character 5. Required: `tx`=1 and `busy`=0 asynchronously. A subsequent strobe sends a full, correct 28-character line.
